inst_fetch_queue: RTL and testbench

//  Multi-issue successor of inst_fetch: PC generator, icache request issue and decoupling instruction queue.

---
 rtl/inst_fetch_queue.sv | 166 ++++++++++++++++
 tb/tb_inst_fetch_queue.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// Multi-issue fetch: PC generation, icache request issue and an in-order
// instruction queue feeding up to N_ISSUE words per cycle to decode.
module inst_fetch_queue #(
  parameter logic [31:0] BOOT_VEC     = 32'hbfc00000,
  parameter int          N_ISSUE      = 2,
  parameter int          FETCH_WIDTH  = 4,
  parameter int          QUEUE_DEPTH  = 8,
  parameter int          MAX_INFLIGHT = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ibus_ready,
  output logic                      ibus_read,
  output logic [31:0]               ibus_vaddr,
  input  logic                      ibus_valid,
  input  logic [32*FETCH_WIDTH-1:0] ibus_rddata,
  input  logic                      branch_valid,
  input  logic [31:0]               branch_target,
  input  logic                      except_valid,
  input  logic [31:0]               except_vec,
  input  logic                      issue_ready,
  output logic [N_ISSUE-1:0]        issue_valid,
  output logic [32*N_ISSUE-1:0]     issue_vaddr,
  output logic [32*N_ISSUE-1:0]     issue_inst
);

  localparam int OW  = $clog2(FETCH_WIDTH);
  localparam int B   = OW + 2;
  localparam int QAW = $clog2(QUEUE_DEPTH);
  localparam int CW  = QAW + 1;
  localparam int IW  = $clog2(MAX_INFLIGHT + 1);
  localparam int FAW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam logic [31-B:0] ONE_BLK = 1;

  logic [31:0]    pc_q, pc_d;
  logic [31:0]    qaddr_q [QUEUE_DEPTH];
  logic [31:0]    qinst_q [QUEUE_DEPTH];
  logic [QAW-1:0] head_q, head_d;
  logic [QAW-1:0] tail_q, tail_d;
  logic [CW-1:0]  count_q, count_d;
  logic [IW-1:0]  infl_q, infl_d;
  logic [IW-1:0]  kill_q, kill_d;
  logic [29:0]    rq_q [MAX_INFLIGHT];
  logic [FAW-1:0] rq_wr_q, rq_wr_d;
  logic [FAW-1:0] rq_rd_q, rq_rd_d;

  logic           redir;
  logic [31:0]    tgt;
  logic [31:0]    need;
  logic           accept;
  logic [29:0]    rsp_w;
  logic [OW-1:0]  rsp_off;
  logic           do_enq;
  logic [CW-1:0]  n_enq, n_avail, n_deq;
  logic [QAW-1:0] rd_idx;

  function automatic logic [FAW-1:0] rq_next(input logic [FAW-1:0] p);
    return (p == FAW'(MAX_INFLIGHT - 1)) ? '0 : p + FAW'(1);
  endfunction

  assign redir   = except_valid | branch_valid;
  assign tgt     = (except_valid ? except_vec : branch_target) & ~32'h3;

  // Reserve space for every outstanding block, dequeue not counted
  assign need    = 32'(count_q)
                 + (32'(infl_q) + 32'd1) * 32'(FETCH_WIDTH);
  assign ibus_read  = ~rst & ~redir
                    & (infl_q < IW'(MAX_INFLIGHT))
                    & (need <= 32'(QUEUE_DEPTH));
  assign ibus_vaddr = pc_q;
  assign accept     = ibus_read & ibus_ready;

  assign rsp_w   = rq_q[rq_rd_q];
  assign rsp_off = rsp_w[OW-1:0];
  assign do_enq  = ibus_valid & ~redir & (kill_q == '0);
  assign n_enq   = do_enq ? CW'(FETCH_WIDTH) - CW'(rsp_off) : '0;
  assign n_avail = (count_q >= CW'(N_ISSUE)) ? CW'(N_ISSUE) : count_q;
  assign n_deq   = (issue_ready & ~redir) ? n_avail : '0;

  always_comb begin
    issue_valid = '0;
    issue_vaddr = '0;
    issue_inst  = '0;
    rd_idx      = '0;
    for (int i = 0; i < N_ISSUE; i++) begin
      rd_idx         = head_q + QAW'(i);
      issue_valid[i] = count_q > CW'(i);
      if (issue_valid[i]) begin
        issue_vaddr[32*i +: 32] = qaddr_q[rd_idx];
        issue_inst[32*i +: 32]  = qinst_q[rd_idx];
      end
    end
  end

  always_comb begin
    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    infl_d  = infl_q;
    kill_d  = kill_q;
    rq_wr_d = accept ? rq_next(rq_wr_q) : rq_wr_q;
    rq_rd_d = ibus_valid ? rq_next(rq_rd_q) : rq_rd_q;
    if (redir) begin
      // Everything still outstanding is now stale
      pc_d    = tgt;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      infl_d  = infl_q - IW'(ibus_valid);
      kill_d  = infl_q - IW'(ibus_valid);
    end else begin
      if (accept)
        pc_d = {pc_q[31:B] + ONE_BLK, {B{1'b0}}};
      infl_d  = infl_q + IW'(accept) - IW'(ibus_valid);
      if (ibus_valid && kill_q != '0)
        kill_d = kill_q - IW'(1);
      head_d  = head_q + QAW'(n_deq);
      tail_d  = tail_q + QAW'(n_enq);
      count_d = count_q + n_enq - n_deq;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= BOOT_VEC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      infl_q  <= '0;
      kill_q  <= '0;
      rq_wr_q <= '0;
      rq_rd_q <= '0;
    end else begin
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      infl_q  <= infl_d;
      kill_q  <= kill_d;
      rq_wr_q <= rq_wr_d;
      rq_rd_q <= rq_rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept)
      rq_q[rq_wr_q] <= pc_q[31:2];
    if (do_enq) begin
      for (int k = 0; k < FETCH_WIDTH; k++) begin
        if (k >= int'(rsp_off)) begin
          qinst_q[tail_q + QAW'(k - int'(rsp_off))] <=
            ibus_rddata[32*k +: 32];
          qaddr_q[tail_q + QAW'(k - int'(rsp_off))] <=
            {rsp_w[29:OW], OW'(k), 2'b00};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && ibus_valid)
      assert (infl_q != '0);
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue with a latency-programmable
// icache model whose memory word equals its own address.
module tb_inst_fetch_queue;

  localparam int NI = 2;
  localparam int FW = 4;
  localparam int MI = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            ibus_ready;
  logic            ibus_read;
  logic [31:0]     ibus_vaddr;
  logic            ibus_valid;
  logic [32*FW-1:0] ibus_rddata;
  logic            branch_valid = 1'b0;
  logic [31:0]     branch_target = '0;
  logic            except_valid = 1'b0;
  logic [31:0]     except_vec = '0;
  logic            issue_ready = 1'b0;
  logic [NI-1:0]   issue_valid;
  logic [32*NI-1:0] issue_vaddr;
  logic [32*NI-1:0] issue_inst;

  inst_fetch_queue #(
    .BOOT_VEC(32'hbfc00000), .N_ISSUE(NI), .FETCH_WIDTH(FW),
    .QUEUE_DEPTH(8), .MAX_INFLIGHT(MI)
  ) dut (
    .clk(clk), .rst(rst),
    .ibus_ready(ibus_ready), .ibus_read(ibus_read),
    .ibus_vaddr(ibus_vaddr), .ibus_valid(ibus_valid),
    .ibus_rddata(ibus_rddata),
    .branch_valid(branch_valid), .branch_target(branch_target),
    .except_valid(except_valid), .except_vec(except_vec),
    .issue_ready(issue_ready), .issue_valid(issue_valid),
    .issue_vaddr(issue_vaddr), .issue_inst(issue_inst)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          lat = 1;
  logic [31:0] sb[$];
  logic [31:0] req_log[$];
  pend_t       pend[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_seq(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) sb.push_back(start + 32'(4 * i));
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb.size() > 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (sb.size() > 0) begin
      fails++;
      $display("FAIL %s_timeout: got %0d pending expected 0", name,
               sb.size());
    end
    sb.delete();
  endtask

  task automatic chk_req(input string name, input int idx,
                         input logic [31:0] exp);
    if (req_log.size() > idx) chk(name, req_log[idx], exp);
    else chk(name, 32'hdeadbeef, exp);
  endtask

  // icache: decides at negedge for the next posedge
  initial begin
    pend_t       p;
    logic [1:0]  kk;
    ibus_valid  = 1'b0;
    ibus_rddata = '0;
    ibus_ready  = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        pend.delete();
        ibus_valid = 1'b0;
      end else begin
        ibus_valid = 1'b0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
          p = pend.pop_front();
          ibus_valid = 1'b1;
          for (int k = 0; k < FW; k++) begin
            kk = 2'(k);
            ibus_rddata[32*k +: 32] = {p.addr[31:4], kk, 2'b00};
          end
        end
        if (ibus_read && ibus_ready) begin
          pend.push_back('{ibus_vaddr, cyc + lat});
          req_log.push_back(ibus_vaddr);
          tests++;
          if (pend.size() > MI) begin
            fails++;
            $display("FAIL inflight: got %0d expected <= %0d",
                     pend.size(), MI);
          end
        end
      end
    end
  end

  // Monitor: pops expectations for every handshaken lane
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!rst && issue_ready && !branch_valid && !except_valid) begin
        if (issue_valid != '0) begin
          tests++;
          if (issue_valid == 2'b10) begin
            fails++;
            $display("FAIL thermo: got %b expected 01/11", issue_valid);
          end
        end
        for (int i = 0; i < NI; i++) begin
          if (issue_valid[i] && sb.size() > 0) begin
            e = sb.pop_front();
            tests++;
            if (issue_vaddr[32*i +: 32] !== e ||
                issue_inst[32*i +: 32] !== e) begin
              fails++;
              $display("FAIL lane%0d: got pc %h inst %h expected %h",
                       i, issue_vaddr[32*i +: 32],
                       issue_inst[32*i +: 32], e);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int n;
    // 1: reset state and boot stream
    repeat (2) @(negedge clk);
    chk("rst_read", 32'(ibus_read), 0);
    chk("rst_valid", 32'(issue_valid), 0);
    chk("rst_vaddr", issue_vaddr[31:0], 0);
    chk("rst_inst", issue_inst[31:0], 0);
    @(posedge clk); #1;
    push_seq(32'hbfc00000, 12);
    issue_ready = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("lat_before", 32'(issue_valid), 0);
    @(negedge clk);
    chk("lat_after", 32'(issue_valid), 3);
    chk_req("boot_req", 0, 32'hbfc00000);
    wait_drain("boot");

    // 2: misaligned branch target mid-block
    @(posedge clk); #1;
    issue_ready = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    sb.delete();
    idx = req_log.size();
    branch_valid = 1'b1;
    branch_target = 32'hbfc0000e;
    push_seq(32'hbfc0000c, 9);
    @(posedge clk); #1;
    branch_valid = 1'b0;
    issue_ready = 1'b1;
    wait_drain("midblk");
    chk_req("midblk_req0", idx, 32'hbfc0000c);
    chk_req("midblk_req1", idx + 1, 32'hbfc00010);

    // 3: latency 3, redirect with two requests in flight
    @(posedge clk); #1;
    sb.delete();
    lat = 3;
    repeat (10) @(posedge clk);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (pend.size() != 2 && n < 50);
    chk("two_inflight", 32'(pend.size()), 2);
    branch_valid = 1'b1;
    branch_target = 32'hbfc00200;
    push_seq(32'hbfc00200, 10);
    @(posedge clk); #1;
    branch_valid = 1'b0;
    wait_drain("stale");

    // 4: exception wins over same-cycle branch
    @(posedge clk); #1;
    lat = 1;
    sb.delete();
    idx = req_log.size();
    except_valid = 1'b1;
    except_vec = 32'hbfc00380;
    branch_valid = 1'b1;
    branch_target = 32'hbfc00100;
    push_seq(32'hbfc00380, 10);
    @(posedge clk); #1;
    except_valid = 1'b0;
    branch_valid = 1'b0;
    wait_drain("prio");
    chk_req("prio_req", idx, 32'hbfc00380);

    // 5: decode stalled long enough to fill the queue
    @(posedge clk); #1;
    issue_ready = 1'b0;
    sb.delete();
    branch_valid = 1'b1;
    branch_target = 32'hbfc00400;
    @(posedge clk); #1;
    branch_valid = 1'b0;
    repeat (20) @(negedge clk);
    chk("full_read", 32'(ibus_read), 0);
    chk("full_valid", 32'(issue_valid), 3);
    chk("full_pend", 32'(pend.size()), 0);
    @(posedge clk); #1;
    push_seq(32'hbfc00400, 12);
    issue_ready = 1'b1;
    wait_drain("full");

    // 6: asynchronous reset mid-stream
    sb.delete();
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(issue_valid), 0);
    chk("arst_read", 32'(ibus_read), 0);
    chk("arst_vaddr", issue_vaddr[31:0], 0);
    @(posedge clk); #3;
    sb.delete();
    idx = req_log.size();
    push_seq(32'hbfc00000, 10);
    rst = 1'b0;
    wait_drain("rearm");
    chk_req("rearm_req", idx, 32'hbfc00000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
